// File: rtl/display_scan_if.sv
// Bus bundle between the counter/score logic and the display sequencer.
//   value  : unsigned binary value to display
//   load   : request, accepted when load && !busy
//   busy   : conversion in progress
//   ovf    : last accepted value exceeded the displayable range (sticky)
//   seg    : segments {g,f,e,d,c,b,a}, active-high
//   dig_en : one-hot digit select, 01=units, 10=tens
// master drives value/load; slave (the sequencer) drives the rest.
interface display_scan_if;
    logic [7:0] value;
    logic       load;
    logic       busy;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] dig_en;

    modport master (
        output value,
        output load,
        input  busy,
        input  ovf,
        input  seg,
        input  dig_en
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output ovf,
        output seg,
        output dig_en
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment display sequencer.
// Accepts an 8-bit value through a load handshake, splits it into tens and
// units by repeated subtract-by-10, commits both digits at once and
// time-multiplexes them onto one shared segment bus.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : display_scan_if.slave (value, load, busy, ovf, seg, dig_en)
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int MAX_VAL     = 81,
    parameter bit BLANK_LEAD  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scan_if.slave        bus
);

    localparam int         CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0] MAX_V = 8'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t            state;
    logic [7:0]        rem;
    logic [3:0]        tcnt;
    logic              ovf_pend;
    logic              busy;
    logic              ovf;
    logic [3:0]        tens;
    logic [3:0]        units;

    logic [CNT_W-1:0]  cnt;
    logic              slot;      // 0 = units, 1 = tens
    logic [6:0]        seg;
    logic [1:0]        dig_en;

    logic              wrap;
    logic              next_slot;
    logic [6:0]        seg_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Conversion FSM. Digits change only in COMMIT so the display never
    // shows a mix of old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= 8'd0;
            tcnt     <= 4'd0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            tens     <= 4'd0;
            units    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load && !busy) begin
                        rem  <= bus.value;
                        tcnt <= 4'd0;
                        busy <= 1'b1;
                        if (bus.value > MAX_V) begin
                            ovf_pend <= 1'b1;
                            state    <= COMMIT;
                        end else begin
                            ovf_pend <= 1'b0;
                            state    <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (rem >= 8'd10) begin
                        rem  <= rem - 8'd10;
                        tcnt <= tcnt + 4'd1;
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // On overflow the previous digits are retained but blanked.
                    if (ovf_pend) begin
                        ovf <= 1'b1;
                    end else begin
                        ovf   <= 1'b0;
                        tens  <= tcnt;
                        units <= rem[3:0];
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Segment content is re-evaluated every cycle for the slot that will be
    // active after this edge, so a commit shows up one edge later without
    // disturbing the slot timing.
    always_comb begin
        wrap      = (cnt == CNT_LAST);
        next_slot = slot ^ wrap;
        seg_next  = 7'b0000000;
        if (ovf) begin
            seg_next = 7'b0000000;
        end else if (next_slot) begin
            if (BLANK_LEAD && (tens == 4'd0))
                seg_next = 7'b0000000;
            else
                seg_next = seg_code(tens);
        end else begin
            seg_next = seg_code(units);
        end
    end

    // Refresh scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            slot   <= 1'b0;
            dig_en <= 2'b01;
            seg    <= 7'b0111111;
        end else begin
            cnt    <= wrap ? '0 : cnt + 1'b1;
            slot   <= next_slot;
            dig_en <= next_slot ? 2'b10 : 2'b01;
            seg    <= seg_next;
        end
    end

    assign bus.busy   = busy;
    assign bus.ovf    = ovf;
    assign bus.seg    = seg;
    assign bus.dig_en = dig_en;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    display_scan_if u_if1 ();
    display_scan_if u_if2 ();

    display_scan_ctrl #(.REFRESH_DIV(4), .MAX_VAL(81), .BLANK_LEAD(1'b0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1.slave)
    );

    display_scan_ctrl #(.REFRESH_DIV(4), .MAX_VAL(81), .BLANK_LEAD(1'b1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive sampled cycles with busy high, starting now.
    task automatic count_busy(input int which, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if ((which == 1) ? u_if2.busy : u_if1.busy) begin
                n++;
                step();
            end else begin
                break;
            end
        end
    endtask

    task automatic load1(input logic [7:0] v);
        u_if1.value = v;
        u_if1.load  = 1'b1;
        step();
        u_if1.load  = 1'b0;
    endtask

    // Wait (bounded) for the given slot to be active, then check its segments.
    task automatic slot_check(input int which, input logic [1:0] en,
                              input logic [6:0] exp, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (((which == 1) ? u_if2.dig_en : u_if1.dig_en) == en) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_slot"}, {31'd0, found}, 32'd1);
        chk(tag, {25'd0, (which == 1) ? u_if2.seg : u_if1.seg}, {25'd0, exp});
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        u_if1.value = 8'd0;
        u_if1.load  = 1'b0;
        u_if2.value = 8'd0;
        u_if2.load  = 1'b0;

        // 1: reset values and idle scanning
        step();
        step();
        chk("rst_busy",   {31'd0, u_if1.busy},   32'd0);
        chk("rst_ovf",    {31'd0, u_if1.ovf},    32'd0);
        chk("rst_dig_en", {30'd0, u_if1.dig_en}, 32'd1);
        chk("rst_seg",    {25'd0, u_if1.seg},    32'h3F);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("idle_dig_en", {30'd0, u_if1.dig_en}, ((k / 4) % 2 == 1) ? 32'd2 : 32'd1);
            chk("idle_seg",    {25'd0, u_if1.seg},    32'h3F);
            chk("idle_busy",   {31'd0, u_if1.busy},   32'd0);
        end
        chk("idle_ovf", {31'd0, u_if1.ovf}, 32'd0);

        // 2: load 47
        load1(8'd47);
        count_busy(0, n);
        chk("busy_47", n, 32'd6);
        chk("ovf_47", {31'd0, u_if1.ovf}, 32'd0);
        step();
        slot_check(0, 2'b01, 7'b0000111, "units_47");
        slot_check(0, 2'b10, 7'b1100110, "tens_47");

        // 3: overflow, then recover with 5
        load1(8'd82);
        count_busy(0, n);
        chk("busy_82", n, 32'd1);
        chk("ovf_82", {31'd0, u_if1.ovf}, 32'd1);
        step();
        slot_check(0, 2'b01, 7'b0000000, "units_82");
        slot_check(0, 2'b10, 7'b0000000, "tens_82");
        load1(8'd5);
        count_busy(0, n);
        chk("busy_5", n, 32'd2);
        chk("ovf_5", {31'd0, u_if1.ovf}, 32'd0);
        step();
        slot_check(0, 2'b01, 7'b1101101, "units_5");
        slot_check(0, 2'b10, 7'b0111111, "tens_5");

        // 4: load 81, load 3 while busy is dropped
        u_if1.value = 8'd81;
        u_if1.load  = 1'b1;
        step();
        u_if1.value = 8'd3;
        step();
        u_if1.load  = 1'b0;
        count_busy(0, n);
        chk("busy_81", n, 32'd9);
        step();
        step();
        chk("no_queue_busy", {31'd0, u_if1.busy}, 32'd0);
        slot_check(0, 2'b10, 7'b1111111, "tens_81");
        slot_check(0, 2'b01, 7'b0000110, "units_81");

        // 5: leading blank on the second instance
        u_if2.value = 8'd7;
        u_if2.load  = 1'b1;
        step();
        u_if2.load  = 1'b0;
        count_busy(1, n);
        chk("busy_7", n, 32'd2);
        step();
        slot_check(1, 2'b10, 7'b0000000, "blank_tens_7");
        slot_check(1, 2'b01, 7'b0000111, "blank_units_7");
        slot_check(1, 2'b10, 7'b0000000, "blank_tens_7b");

        // 6: reset in the third CONV cycle of a load of 60
        load1(8'd60);
        step();
        step();
        chk("pre_rst_busy", {31'd0, u_if1.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, u_if1.busy},   32'd0);
        chk("abort_ovf",    {31'd0, u_if1.ovf},    32'd0);
        chk("abort_dig_en", {30'd0, u_if1.dig_en}, 32'd1);
        chk("abort_seg",    {25'd0, u_if1.seg},    32'h3F);
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("post_rst_seg",  {25'd0, u_if1.seg},  32'h3F);
            chk("post_rst_busy", {31'd0, u_if1.busy}, 32'd0);
            chk("post_rst_dig_en", {30'd0, u_if1.dig_en}, ((k / 4) % 2 == 1) ? 32'd2 : 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
